// File: rtl/clk_edge_monitor_if.sv
// Bundles the monitored input, restart control and measurement results of clk_edge_monitor.
// The master drives mon_in/clear and observes results; the slave is the monitor itself.
interface clk_edge_monitor_if #(
   parameter int unsigned CNT_W = 16
);
   logic             mon_in;
   logic             clear;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W-1:0] posedge_cnt;
   logic             err_high;
   logic             err_low;
   logic             err_stuck;
   logic             done;

   modport master (
      output mon_in, clear,
      input  rise_pulse, fall_pulse, high_len, low_len, posedge_cnt,
             err_high, err_low, err_stuck, done
   );

   modport slave (
      input  mon_in, clear,
      output rise_pulse, fall_pulse, high_len, low_len, posedge_cnt,
             err_high, err_low, err_stuck, done
   );
endinterface

// File: rtl/clk_edge_monitor.sv
// Synchronizes an asynchronous clock-like signal, measures its high/low phase lengths in clk
// cycles, counts rising edges and flags out-of-tolerance or stuck behaviour.
module clk_edge_monitor #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned EXP_HIGH  = 1,
   parameter int unsigned EXP_LOW   = 1,
   parameter int unsigned TOL       = 0,
   parameter int unsigned N_CYCLES  = 10,
   parameter int unsigned STUCK_LIM = 1000
) (
   input logic               clk,
   input logic               rst,
   clk_edge_monitor_if.slave mon_if
);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam int unsigned      HIGH_MIN = (EXP_HIGH > TOL) ? EXP_HIGH - TOL : 32'd0;
   localparam int unsigned      HIGH_MAX = EXP_HIGH + TOL;
   localparam int unsigned      LOW_MIN  = (EXP_LOW > TOL) ? EXP_LOW - TOL : 32'd0;
   localparam int unsigned      LOW_MAX  = EXP_LOW + TOL;

   typedef enum logic [1:0] {
      WAIT_EDGE = 2'd0,
      MEASURE   = 2'd1,
      DONE      = 2'd2
   } state_e;

   state_e           state_q;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] posedge_cnt_q, posedge_cnt_d;
   logic [CNT_W-1:0] high_len_q, low_len_q;
   logic             err_high_q, err_low_q, err_stuck_q, done_q;

   logic             rise_c, fall_c;
   logic [31:0]      run_ext_c;
   logic             high_bad_c, low_bad_c, stuck_c, hit_n_c;

   // Edge strobes decode the last two synchronizer stages.
   assign rise_c = s2_q & ~s3_q;
   assign fall_c = ~s2_q & s3_q;

   // Saturating counters and tolerance checks on the run length ending this cycle.
   always_comb begin
      run_cnt_d     = run_cnt_q;
      posedge_cnt_d = posedge_cnt_q;
      if (rise_c || fall_c) begin
         run_cnt_d = CNT_W'(1);
      end else if (run_cnt_q != CNT_MAX) begin
         run_cnt_d = run_cnt_q + CNT_W'(1);
      end
      if (posedge_cnt_q != CNT_MAX) begin
         posedge_cnt_d = posedge_cnt_q + CNT_W'(1);
      end
   end

   assign run_ext_c  = 32'(run_cnt_q);
   assign high_bad_c = (run_ext_c < HIGH_MIN) || (run_ext_c > HIGH_MAX);
   assign low_bad_c  = (run_ext_c < LOW_MIN) || (run_ext_c > LOW_MAX);
   assign stuck_c    = (run_ext_c >= STUCK_LIM);
   assign hit_n_c    = (32'(posedge_cnt_d) == N_CYCLES);

   // Synchronizer, measurement state machine and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         state_q       <= WAIT_EDGE;
         run_cnt_q     <= '0;
         posedge_cnt_q <= '0;
         high_len_q    <= '0;
         low_len_q     <= '0;
         err_high_q    <= 1'b0;
         err_low_q     <= 1'b0;
         err_stuck_q   <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         s1_q <= mon_if.mon_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
         // Clear restarts measurement but keeps the synchronizer history.
         if (mon_if.clear) begin
            state_q       <= WAIT_EDGE;
            run_cnt_q     <= '0;
            posedge_cnt_q <= '0;
            high_len_q    <= '0;
            low_len_q     <= '0;
            err_high_q    <= 1'b0;
            err_low_q     <= 1'b0;
            err_stuck_q   <= 1'b0;
            done_q        <= 1'b0;
         end else begin
            run_cnt_q <= run_cnt_d;
            if ((state_q != DONE) && stuck_c) begin
               err_stuck_q <= 1'b1;
            end
            case (state_q)
               WAIT_EDGE: begin
                  if (rise_c) begin
                     posedge_cnt_q <= posedge_cnt_d;
                     if (hit_n_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= MEASURE;
                     end
                  end else if (fall_c) begin
                     state_q <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (fall_c) begin
                     high_len_q <= run_cnt_q;
                     if (high_bad_c) err_high_q <= 1'b1;
                  end
                  if (rise_c) begin
                     low_len_q     <= run_cnt_q;
                     posedge_cnt_q <= posedge_cnt_d;
                     if (low_bad_c) err_low_q <= 1'b1;
                     if (hit_n_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               DONE: begin
               end
               default: state_q <= WAIT_EDGE;
            endcase
         end
      end
   end

   assign mon_if.rise_pulse  = rise_c;
   assign mon_if.fall_pulse  = fall_c;
   assign mon_if.high_len    = high_len_q;
   assign mon_if.low_len     = low_len_q;
   assign mon_if.posedge_cnt = posedge_cnt_q;
   assign mon_if.err_high    = err_high_q;
   assign mon_if.err_low     = err_low_q;
   assign mon_if.err_stuck   = err_stuck_q;
   assign mon_if.done        = done_q;
endmodule

// File: tb/tb_clk_edge_monitor.sv
// Self-checking bench for clk_edge_monitor: directed scenarios plus randomized phase
// patterns compared against a phase-level reference model.
module tb_clk_edge_monitor;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned EXP_HIGH  = 3;
   localparam int unsigned EXP_LOW   = 5;
   localparam int unsigned TOL       = 0;
   localparam int unsigned N_CYCLES  = 10;
   localparam int unsigned STUCK_LIM = 20;
   localparam int          CNT_MAX_I = (1 << CNT_W) - 1;
   localparam int          VW        = 3 * CNT_W + 6;

   logic clk = 1'b0;
   logic rst;

   clk_edge_monitor_if #(.CNT_W(CNT_W)) mon_if ();

   clk_edge_monitor #(
      .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW), .TOL(TOL),
      .N_CYCLES(N_CYCLES), .STUCK_LIM(STUCK_LIM)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .mon_if(mon_if.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: seen level history, run length since last edge, and results.
   bit h1, h2, h3;
   int m_run, m_hl, m_ll, m_pc;
   bit m_eh, m_el, m_es, m_done;
   int m_mode;  // 0 waiting for first edge, 1 measuring, 2 finished

   function automatic int sat(input int v);
      return (v > CNT_MAX_I) ? CNT_MAX_I : v;
   endfunction

   function automatic bit out_of_tol(input int len, input int expv);
      int d;
      d = len - expv;
      if (d < 0) d = -d;
      return d > int'(TOL);
   endfunction

   task automatic model_zero();
      m_run = 0; m_hl = 0; m_ll = 0; m_pc = 0;
      m_eh = 0; m_el = 0; m_es = 0; m_done = 0; m_mode = 0;
   endtask

   task automatic model_edge(input bit r, input bit c, input bit m);
      bit rs, fs;
      int prev;
      rs = h2 && !h3;
      fs = !h2 && h3;
      if (r) begin
         h1 = 0; h2 = 0; h3 = 0;
         model_zero();
      end else begin
         h3 = h2; h2 = h1; h1 = m;
         if (c) begin
            model_zero();
         end else begin
            prev  = m_run;
            m_run = (rs || fs) ? 1 : sat(m_run + 1);
            if (m_mode != 2) begin
               if (prev >= int'(STUCK_LIM)) m_es = 1;
               if (rs || fs) begin
                  if (m_mode == 1 && fs) begin
                     m_hl = prev;
                     if (out_of_tol(prev, int'(EXP_HIGH))) m_eh = 1;
                  end
                  if (m_mode == 1 && rs) begin
                     m_ll = prev;
                     if (out_of_tol(prev, int'(EXP_LOW))) m_el = 1;
                  end
                  m_mode = 1;
                  if (rs) begin
                     m_pc = sat(m_pc + 1);
                     if (m_pc == int'(N_CYCLES)) begin
                        m_mode = 2;
                        m_done = 1;
                     end
                  end
               end
            end
         end
      end
   endtask

   // One clk cycle: drive at negedge, model at posedge, return at next negedge.
   task automatic tick(input bit r, input bit c, input bit m);
      rst = r;
      mon_if.clear  = c;
      mon_if.mon_in = m;
      @(posedge clk);
      model_edge(r, c, m);
      @(negedge clk);
   endtask

   task automatic drive(input bit lvl, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, lvl);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if ({mon_if.rise_pulse, mon_if.fall_pulse} !== 2'b00) begin
         failures++;
         $display("FAIL reset_strobes: got %b expected 00", {mon_if.rise_pulse, mon_if.fall_pulse});
      end
      checks++;
      if ({mon_if.high_len, mon_if.low_len, mon_if.posedge_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_counts: got hl=%0d ll=%0d pc=%0d expected 0", mon_if.high_len,
                  mon_if.low_len, mon_if.posedge_cnt);
      end
      checks++;
      if ({mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done});
      end
   endtask

   task automatic test_nominal();
      drive(1'b0, 4);
      tick(1'b0, 1'b1, 1'b0);
      // Rise strobe appears only in the cycle after the second sampling edge.
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if (mon_if.rise_pulse !== 1'b0) begin
         failures++;
         $display("FAIL rise_latency_early: got %b expected 0", mon_if.rise_pulse);
      end
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if (mon_if.rise_pulse !== 1'b1) begin
         failures++;
         $display("FAIL rise_latency: got %b expected 1", mon_if.rise_pulse);
      end
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if (mon_if.rise_pulse !== 1'b0) begin
         failures++;
         $display("FAIL rise_one_cycle: got %b expected 0", mon_if.rise_pulse);
      end
      drive(1'b0, 5);
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 3);
         drive(1'b0, 5);
      end
      checks++;
      if (mon_if.high_len !== 16'd3 || mon_if.low_len !== 16'd5) begin
         failures++;
         $display("FAIL nominal_len: got hl=%0d ll=%0d expected hl=3 ll=5", mon_if.high_len,
                  mon_if.low_len);
      end
      checks++;
      if ({mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done} !== 4'b0000) begin
         failures++;
         $display("FAIL nominal_flags: got %b expected 0000",
                  {mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done});
      end
      checks++;
      if (mon_if.posedge_cnt !== 16'd4) begin
         failures++;
         $display("FAIL nominal_pc: got %0d expected 4", mon_if.posedge_cnt);
      end
   endtask

   task automatic test_toggle();
      bit m;
      m = 1'b0;
      drive(1'b0, 3);
      tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 34; i++) begin
         m = ~m;
         tick(1'b0, 1'b0, m);
         checks++;
         if (mon_if.done !== m_done || int'(mon_if.posedge_cnt) != m_pc) begin
            failures++;
            $display("FAIL toggle_cycle%0d: got done=%b pc=%0d expected done=%b pc=%0d", i,
                     mon_if.done, mon_if.posedge_cnt, m_done, m_pc);
         end
      end
      checks++;
      if (mon_if.done !== 1'b1 || mon_if.posedge_cnt !== 16'd10) begin
         failures++;
         $display("FAIL toggle_done: got done=%b pc=%0d expected done=1 pc=10", mon_if.done,
                  mon_if.posedge_cnt);
      end
   endtask

   task automatic test_err_high();
      bit found;
      found = 1'b0;
      drive(1'b0, 3);
      tick(1'b0, 1'b1, 1'b0);
      drive(1'b1, 3);
      drive(1'b0, 5);
      checks++;
      if (mon_if.err_high !== 1'b0) begin
         failures++;
         $display("FAIL err_high_before: got %b expected 0", mon_if.err_high);
      end
      drive(1'b1, 4);
      for (int i = 0; i < 6 && !found; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (mon_if.fall_pulse === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL err_high_fall_timeout: got no fall_pulse expected one within 6 cycles");
      end else if (mon_if.err_high !== 1'b0) begin
         failures++;
         $display("FAIL err_high_at_fall: got %b expected 0", mon_if.err_high);
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (mon_if.err_high !== 1'b1 || mon_if.high_len !== 16'd4) begin
         failures++;
         $display("FAIL err_high_set: got err=%b hl=%0d expected err=1 hl=4", mon_if.err_high,
                  mon_if.high_len);
      end
      drive(1'b0, 2);
      drive(1'b1, 3);
      drive(1'b0, 5);
      checks++;
      if (mon_if.err_high !== 1'b1 || mon_if.high_len !== 16'd3 || mon_if.err_low !== 1'b0) begin
         failures++;
         $display("FAIL err_high_sticky: got err=%b hl=%0d el=%b expected err=1 hl=3 el=0",
                  mon_if.err_high, mon_if.high_len, mon_if.err_low);
      end
   endtask

   task automatic test_stuck();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 30; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (i == 15) begin
            checks++;
            if (mon_if.err_stuck !== 1'b0) begin
               failures++;
               $display("FAIL stuck_early: got %b expected 0", mon_if.err_stuck);
            end
         end
      end
      checks++;
      if (mon_if.err_stuck !== 1'b1 || mon_if.done !== 1'b0) begin
         failures++;
         $display("FAIL stuck_set: got es=%b done=%b expected es=1 done=0", mon_if.err_stuck,
                  mon_if.done);
      end
   endtask

   task automatic test_clear_in_done();
      bit m, found;
      m = 1'b0;
      found = 1'b0;
      drive(1'b0, 3);
      tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40 && !m_done; i++) begin
         m = ~m;
         tick(1'b0, 1'b0, m);
      end
      for (int i = 0; i < 6 && !found; i++) begin
         if (mon_if.rise_pulse === 1'b1) begin
            found = 1'b1;
         end else begin
            m = ~m;
            tick(1'b0, 1'b0, m);
         end
      end
      checks++;
      if (!found || mon_if.done !== 1'b1) begin
         failures++;
         $display("FAIL clear_done_setup: got rise_seen=%b done=%b expected 1 1", found,
                  mon_if.done);
      end
      m = ~m;
      tick(1'b0, 1'b1, m);
      checks++;
      if ({mon_if.high_len, mon_if.low_len, mon_if.posedge_cnt} !== '0 ||
          {mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done} !== 4'b0000) begin
         failures++;
         $display("FAIL clear_in_done: got hl=%0d ll=%0d pc=%0d flags=%b expected all 0",
                  mon_if.high_len, mon_if.low_len, mon_if.posedge_cnt,
                  {mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done});
      end
      for (int i = 0; i < 4; i++) begin
         m = ~m;
         tick(1'b0, 1'b0, m);
      end
      checks++;
      if (int'(mon_if.posedge_cnt) != m_pc || mon_if.done !== 1'b0) begin
         failures++;
         $display("FAIL clear_restart: got pc=%0d done=%b expected pc=%0d done=0",
                  mon_if.posedge_cnt, mon_if.done, m_pc);
      end
   endtask

   task automatic test_rst_mid();
      drive(1'b0, 2);
      tick(1'b0, 1'b1, 1'b0);
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 2);
         drive(1'b0, 2);
      end
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 2);
         drive(1'b0, 2);
      end
      checks++;
      if (mon_if.high_len !== 16'd2 || mon_if.low_len !== 16'd2 ||
          mon_if.posedge_cnt !== 16'd4) begin
         failures++;
         $display("FAIL rst_mid: got hl=%0d ll=%0d pc=%0d expected hl=2 ll=2 pc=4",
                  mon_if.high_len, mon_if.low_len, mon_if.posedge_cnt);
      end
   endtask

   task automatic test_random();
      bit lvl, c, r;
      int remain;
      logic [VW-1:0] got, exp;
      lvl = 1'b0;
      remain = 0;
      for (int i = 0; i < 400; i++) begin
         if (remain == 0) begin
            lvl = ~lvl;
            remain = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 25))
                                                 : int'($urandom_range(1, 7));
         end
         c = ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 149) == 0);
         tick(r, c, lvl);
         remain--;
         got = {mon_if.rise_pulse, mon_if.fall_pulse, mon_if.high_len, mon_if.low_len,
                mon_if.posedge_cnt, mon_if.err_high, mon_if.err_low, mon_if.err_stuck, mon_if.done};
         exp = {h2 && !h3, !h2 && h3, CNT_W'(m_hl), CNT_W'(m_ll), CNT_W'(m_pc),
                m_eh, m_el, m_es, m_done};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random_cycle%0d: got %h expected %h", i, got, exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      mon_if.clear  = 1'b0;
      mon_if.mon_in = 1'b0;
      @(negedge clk);
      test_reset();
      test_nominal();
      test_toggle();
      test_err_high();
      test_stuck();
      test_clear_in_done();
      test_rst_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
